// File: rtl/baud_acq_generator_pkg.sv
// rtl/baud_acq_generator_pkg.sv - shared UART timing widths and limits
package baud_acq_generator_pkg;

    localparam int UART_DIV_W   = 16;
    localparam int UART_ACQN_W  = 4;
    localparam int UART_DIV_MIN = 2;
    localparam int UART_FRAC_W  = 4;

endpackage

// File: rtl/baud_acq_generator_if.sv
// rtl/baud_acq_generator_if.sv - control/strobe bundle; BaudFrac_i present under BAUD_ACQ_FRAC_EN
interface baud_acq_generator_if
    import baud_acq_generator_pkg::*;
#(
    parameter int DIV_W  = UART_DIV_W,
    parameter int ACQN_W = UART_ACQN_W
);

    logic              p_Enable_i;
    logic [DIV_W-1:0]  BaudDivide_i;
    logic [ACQN_W-1:0] AcqNumPerBit_i;
    logic              p_Resync_i;
    logic              AcqSig_o;
    logic              BaudSig_o;
    logic [ACQN_W-1:0] BitPhase_o;

`ifdef BAUD_ACQ_FRAC_EN
    logic [UART_FRAC_W-1:0] BaudFrac_i;

    modport master (
        output p_Enable_i, BaudDivide_i, AcqNumPerBit_i, p_Resync_i, BaudFrac_i,
        input  AcqSig_o, BaudSig_o, BitPhase_o
    );

    modport slave (
        input  p_Enable_i, BaudDivide_i, AcqNumPerBit_i, p_Resync_i, BaudFrac_i,
        output AcqSig_o, BaudSig_o, BitPhase_o
    );
`else
    modport master (
        output p_Enable_i, BaudDivide_i, AcqNumPerBit_i, p_Resync_i,
        input  AcqSig_o, BaudSig_o, BitPhase_o
    );

    modport slave (
        input  p_Enable_i, BaudDivide_i, AcqNumPerBit_i, p_Resync_i,
        output AcqSig_o, BaudSig_o, BitPhase_o
    );
`endif

endinterface

// File: rtl/baud_frac_accum.sv
// rtl/baud_frac_accum.sv - fractional phase accumulator; carry stretches the next acquisition period
module baud_frac_accum
    import baud_acq_generator_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   step,
    input  logic [UART_FRAC_W-1:0] frac,
    output logic                   carry_o
);

    logic [UART_FRAC_W-1:0] acc_d, acc_q;
    logic                   carry_d, carry_q;

    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        if (clear) begin
            acc_d   = '0;
            carry_d = 1'b0;
        end else if (step) begin
            {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, frac};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign carry_o = carry_q;

endmodule

// File: rtl/baud_acq_generator.sv
// rtl/baud_acq_generator.sv - acquisition/baud strobe generator; BAUD_ACQ_FRAC_EN adds fractional division
module baud_acq_generator
    import baud_acq_generator_pkg::*;
#(
    parameter int DIV_W  = UART_DIV_W,
    parameter int ACQN_W = UART_ACQN_W
)(
    input  logic                 clk,
    input  logic                 rst,
    baud_acq_generator_if.slave  bus
);

    logic [DIV_W-1:0]  acq_cnt_d, acq_cnt_q;
    logic [DIV_W-1:0]  div_d, div_q, div_in;
    logic [ACQN_W-1:0] bit_cnt_d, bit_cnt_q;
    logic [ACQN_W-1:0] n_d, n_q, n_in;
    logic              acq_sig_d, acq_sig_q;
    logic              baud_sig_d, baud_sig_q;
    logic              en_d, en_q;
    logic              restart, terminal, wrap, latch;
    logic              stretch;

    assign div_in = (bus.BaudDivide_i < DIV_W'(UART_DIV_MIN)) ? DIV_W'(UART_DIV_MIN) : bus.BaudDivide_i;
    assign n_in   = (bus.AcqNumPerBit_i == '0) ? ACQN_W'(1) : bus.AcqNumPerBit_i;

    // Enable rise and resync both restart the phase and reload the divisor latches.
    assign restart  = bus.p_Enable_i && (!en_q || bus.p_Resync_i);
    assign terminal = bus.p_Enable_i && !restart &&
                      (acq_cnt_q == div_q - DIV_W'(1) + DIV_W'(stretch));
    assign wrap     = terminal && (bit_cnt_q == n_q - ACQN_W'(1));
    assign latch    = restart || wrap;

`ifdef BAUD_ACQ_FRAC_EN
    logic [UART_FRAC_W-1:0] frac_d, frac_q;

    assign frac_d = latch ? bus.BaudFrac_i : frac_q;

    always_ff @(posedge clk) begin
        if (!rst) frac_q <= bus.BaudFrac_i;
        else      frac_q <= frac_d;
    end

    baud_frac_accum u_frac (
        .clk     (clk),
        .rst     (rst),
        .clear   (!bus.p_Enable_i || restart),
        .step    (terminal),
        .frac    (frac_q),
        .carry_o (stretch)
    );
`else
    assign stretch = 1'b0;
`endif

    always_comb begin
        en_d       = bus.p_Enable_i;
        acq_cnt_d  = '0;
        bit_cnt_d  = '0;
        acq_sig_d  = 1'b0;
        baud_sig_d = 1'b0;
        div_d      = latch ? div_in : div_q;
        n_d        = latch ? n_in : n_q;
        if (bus.p_Enable_i && !restart) begin
            if (terminal) begin
                acq_sig_d  = 1'b1;
                baud_sig_d = wrap;
                bit_cnt_d  = wrap ? '0 : bit_cnt_q + ACQN_W'(1);
            end else begin
                acq_cnt_d = acq_cnt_q + DIV_W'(1);
                bit_cnt_d = bit_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acq_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            acq_sig_q  <= 1'b0;
            baud_sig_q <= 1'b0;
            en_q       <= 1'b0;
            div_q      <= div_in;
            n_q        <= n_in;
        end else begin
            acq_cnt_q  <= acq_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            acq_sig_q  <= acq_sig_d;
            baud_sig_q <= baud_sig_d;
            en_q       <= en_d;
            div_q      <= div_d;
            n_q        <= n_d;
        end
    end

    assign bus.AcqSig_o   = acq_sig_q;
    assign bus.BaudSig_o  = baud_sig_q;
    assign bus.BitPhase_o = bit_cnt_q;

endmodule

// File: tb/tb_baud_acq_generator.sv
// tb/tb_baud_acq_generator.sv - directed bench with event-schedule model for baud_acq_generator
module tb_baud_acq_generator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    baud_acq_generator_if #(.DIV_W(16), .ACQN_W(4)) bus ();

    baud_acq_generator #(.DIV_W(16), .ACQN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int edge_no  = 0;

    // Model: a scheduled "next strobe edge" plus bit index, rebuilt on restarts.
    bit running = 0;
    int ldiv, ln, lfrac, acc, next_edge, bitp;
    bit exp_acq = 0, exp_baud = 0;
    int exp_phase = 0;

    int acq_q[$];
    int ph_q[$];
    int baud_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -100000;
    endfunction

    function automatic int frac_in();
`ifdef BAUD_ACQ_FRAC_EN
        return int'(bus.BaudFrac_i);
`else
        return 0;
`endif
    endfunction

    task automatic latch_inputs();
        ldiv  = (int'(bus.BaudDivide_i) < 2) ? 2 : int'(bus.BaudDivide_i);
        ln    = (int'(bus.AcqNumPerBit_i) == 0) ? 1 : int'(bus.AcqNumPerBit_i);
        lfrac = frac_in();
    endtask

    task automatic model_step();
        int carry;
        exp_acq  = 0;
        exp_baud = 0;
        if (!rst) begin
            running = 0;
            bitp    = 0;
            latch_inputs();
        end else if (!bus.p_Enable_i) begin
            running = 0;
            bitp    = 0;
        end else if (!running || bus.p_Resync_i) begin
            running = 1;
            latch_inputs();
            acc       = 0;
            bitp      = 0;
            next_edge = edge_no + ldiv;
        end else if (edge_no == next_edge) begin
            exp_acq  = 1;
            bitp     = (bitp + 1) % ln;
            exp_baud = (bitp == 0);
            acc      = acc + lfrac;
            carry    = (acc >= 16) ? 1 : 0;
            acc      = acc % 16;
            if (exp_baud) latch_inputs();
            next_edge = edge_no + ldiv + carry;
        end
        exp_phase = bitp;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_no++;
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("acq_sig", int'(bus.AcqSig_o), int'(exp_acq));
            check("baud_sig", int'(bus.BaudSig_o), int'(exp_baud));
            check("bit_phase", int'(bus.BitPhase_o), exp_phase);
            if (bus.AcqSig_o) begin
                acq_q.push_back(edge_no);
                ph_q.push_back(int'(bus.BitPhase_o));
            end
            if (bus.BaudSig_o) baud_q.push_back(edge_no);
        end
    end

    task automatic wait_edge(input int t);
        while (edge_no < t) @(negedge clk);
    endtask

    task automatic restart(output int e);
        bus.p_Enable_i = 1'b0;
        @(negedge clk);
        acq_q.delete();
        ph_q.delete();
        baud_q.delete();
        bus.p_Enable_i = 1'b1;
        e = edge_no + 1;
    endtask

    task automatic pulse_rs(input int t);
        while (edge_no < t - 1) @(negedge clk);
        bus.p_Resync_i = 1'b1;
        @(negedge clk);
        bus.p_Resync_i = 1'b0;
    endtask

    task automatic drive_en(input int t, input logic v);
        while (edge_no < t - 1) @(negedge clk);
        bus.p_Enable_i = v;
        @(negedge clk);
    endtask

    initial begin
        int e;
        rst                = 1'b0;
        bus.p_Enable_i     = 1'b0;
        bus.BaudDivide_i   = 16'd10;
        bus.AcqNumPerBit_i = 4'd4;
        bus.p_Resync_i     = 1'b0;
`ifdef BAUD_ACQ_FRAC_EN
        bus.BaudFrac_i     = 4'd0;
`endif
        repeat (3) @(negedge clk);
        check("reset_acq", int'(bus.AcqSig_o), 0);
        check("reset_baud", int'(bus.BaudSig_o), 0);
        check("reset_phase", int'(bus.BitPhase_o), 0);
        rst = 1'b1;

        // Div=10, N=4 free-running
        restart(e);
        wait_edge(e + 85);
        check("t1_first_acq", qget(acq_q, 0) - e, 10);
        check("t1_acq_gap", qget(acq_q, 1) - qget(acq_q, 0), 10);
        check("t1_acq_count", acq_q.size(), 8);
        check("t1_baud_first", qget(baud_q, 0) - e, 40);
        check("t1_baud_gap", qget(baud_q, 1) - qget(baud_q, 0), 40);

        // Resync 23 clks after enable
        restart(e);
        pulse_rs(e + 23);
        check("t2_acq_at_rs", int'(bus.AcqSig_o), 0);
        check("t2_phase_at_rs", int'(bus.BitPhase_o), 0);
        wait_edge(e + 35);
        check("t2_count", acq_q.size(), 3);
        check("t2_next_acq", qget(acq_q, 2) - e, 33);
        check("t2_next_phase", qget(ph_q, 2), 1);

        // Resync coincident with terminal count of the 4th acquisition
        restart(e);
        pulse_rs(e + 40);
        check("t3_acq_at_tc", int'(bus.AcqSig_o), 0);
        check("t3_baud_at_tc", int'(bus.BaudSig_o), 0);
        check("t3_phase_at_tc", int'(bus.BitPhase_o), 0);
        wait_edge(e + 52);
        check("t3_count", acq_q.size(), 4);
        check("t3_baud_count", baud_q.size(), 0);
        check("t3_next_acq", qget(acq_q, 3) - e, 50);
        check("t3_next_phase", qget(ph_q, 3), 1);

        // Divisor change mid-bit takes effect after BaudSig
        restart(e);
        wait_edge(e + 15);
        bus.BaudDivide_i = 16'd6;
        wait_edge(e + 66);
        check("t4_count", acq_q.size(), 8);
        check("t4_old_gap", qget(acq_q, 3) - qget(acq_q, 2), 10);
        check("t4_new_gap", qget(acq_q, 4) - qget(acq_q, 3), 6);
        check("t4_baud0", qget(baud_q, 0) - e, 40);
        check("t4_baud1", qget(baud_q, 1) - e, 64);

        // Clamps: Div=0 -> 2, N=0 -> 1
        bus.BaudDivide_i   = 16'd0;
        bus.AcqNumPerBit_i = 4'd0;
        restart(e);
        wait_edge(e + 20);
        check("clamp_first", qget(acq_q, 0) - e, 2);
        check("clamp_gap", qget(acq_q, 1) - qget(acq_q, 0), 2);
        check("clamp_count", acq_q.size(), 10);
        check("clamp_baud_count", baud_q.size(), 10);

        // Disable for 5 clks mid-bit
        bus.BaudDivide_i   = 16'd10;
        bus.AcqNumPerBit_i = 4'd4;
        restart(e);
        drive_en(e + 25, 1'b0);
        check("t5_acq_off", int'(bus.AcqSig_o), 0);
        check("t5_phase_off", int'(bus.BitPhase_o), 0);
        drive_en(e + 30, 1'b1);
        wait_edge(e + 42);
        check("t5_count", acq_q.size(), 3);
        check("t5_reenable_acq", qget(acq_q, 2) - e, 40);
        check("t5_reenable_phase", qget(ph_q, 2), 1);

`ifdef BAUD_ACQ_FRAC_EN
        // Div=10, frac=4/16: four stretched periods per 16 acquisitions
        begin
            int n11;
            bus.BaudFrac_i = 4'd4;
            restart(e);
            wait_edge(e + 180);
            check("t6_enough", int'(acq_q.size() >= 17), 1);
            check("t6_first", qget(acq_q, 0) - e, 10);
            n11 = 0;
            for (int i = 1; i <= 16; i++)
                if (qget(acq_q, i) - qget(acq_q, i - 1) == 11) n11++;
            check("t6_long_periods", n11, 4);
            check("t6_total", qget(acq_q, 16) - qget(acq_q, 0), 164);
        end
`endif

        bus.p_Enable_i = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
